qam_symbol_scheduler: RTL and testbench

//  Symbol-rate read controller between the 16-bit transmit FIFO and the QAM mapper.

---
 rtl/qam_symbol_scheduler.sv | 138 +++++++++++++
 tb/tb_qam_symbol_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/qam_symbol_scheduler.sv
// Symbol-rate read controller: primes on FIFO level, pops one 16-bit word per four
// symbol periods and emits it LS nibble first, with underrun stats and XON/XOFF.
module qam_symbol_scheduler #(
  parameter int SYM_PERIOD  = 25000,
  parameter int PERIOD_W    = 19,
  parameter int START_LEVEL = 64,
  parameter int XOFF_LEVEL  = 7168,
  parameter int XON_LEVEL   = 4096
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic        ipEnable,
  input  logic        ipClearStats,
  input  logic [15:0] ipFifoData,
  input  logic        ipFifoEmpty,
  input  logic [12:0] ipFifoCount,
  output logic        opFifoRdEn,
  output logic [3:0]  opSymbol,
  output logic        opSymbolValid,
  output logic        opUnderrun,
  output logic [15:0] opUnderrunCount,
  output logic        opFlowStop,
  output logic [1:0]  opState
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_e;

  localparam logic [PERIOD_W-1:0] LAST    = PERIOD_W'(SYM_PERIOD - 1);
  localparam logic [12:0]         START_C = 13'(START_LEVEL);
  localparam logic [12:0]         XOFF_C  = 13'(XOFF_LEVEL);
  localparam logic [12:0]         XON_C   = 13'(XON_LEVEL);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [1:0]          nib_q, nib_d;
  logic [15:0]         hold_q, hold_d;
  logic [3:0]          sym_q, sym_d;
  logic                vld_q, vld_d;
  logic                rden_q, rden_d;
  logic                und_q, und_d;
  logic [15:0]         ucnt_q, ucnt_d;
  logic                flow_q, flow_d;
  logic                tick;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nib_q   <= '0;
      hold_q  <= '0;
      sym_q   <= '0;
      vld_q   <= 1'b0;
      rden_q  <= 1'b0;
      und_q   <= 1'b0;
      ucnt_q  <= '0;
      flow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      hold_q  <= hold_d;
      sym_q   <= sym_d;
      vld_q   <= vld_d;
      rden_q  <= rden_d;
      und_q   <= und_d;
      ucnt_q  <= ucnt_d;
      flow_q  <= flow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    hold_d  = hold_q;
    sym_d   = sym_q;
    vld_d   = 1'b0;
    rden_d  = 1'b0;
    und_d   = 1'b0;
    ucnt_d  = ucnt_q;

    flow_d = flow_q;
    if (ipFifoCount >= XOFF_C)     flow_d = 1'b1;
    else if (ipFifoCount <= XON_C) flow_d = 1'b0;

    case (state_q)
      IDLE: if (ipEnable) state_d = PRIME;
      PRIME: begin
        if (!ipEnable) state_d = IDLE;
        else if (ipFifoCount >= START_C && !ipFifoEmpty) begin
          state_d = RUN;
          cnt_d   = '0;
          nib_d   = '0;
        end
      end
      RUN: begin
        // Disable only takes effect on a word boundary so words are never split.
        if (!ipEnable && nib_q == 2'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (nib_q != 2'd0) begin
              sym_d = hold_q[{nib_q, 2'b00} +: 4];
              vld_d = 1'b1;
              nib_d = nib_q + 2'd1;
            end else if (ipFifoEmpty) begin
              und_d   = 1'b1;
              state_d = PRIME;
              if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 1'b1;
            end else begin
              hold_d = ipFifoData;
              sym_d  = ipFifoData[3:0];
              vld_d  = 1'b1;
              rden_d = 1'b1;
              nib_d  = 2'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ipClearStats) ucnt_d = '0;
  end

  assign opFifoRdEn      = rden_q;
  assign opSymbol        = sym_q;
  assign opSymbolValid   = vld_q;
  assign opUnderrun      = und_q;
  assign opUnderrunCount = ucnt_q;
  assign opFlowStop      = flow_q;
  assign opState         = state_q;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Scoreboard bench for qam_symbol_scheduler with a small show-ahead FIFO model.
module tb_qam_symbol_scheduler;

  logic        ipClk = 1'b0;
  logic        ipReset = 1'b1;
  logic        ipEnable = 1'b0;
  logic        ipClearStats = 1'b0;
  logic [15:0] ipFifoData;
  logic        ipFifoEmpty;
  logic [12:0] ipFifoCount;
  logic        opFifoRdEn, opSymbolValid, opUnderrun, opFlowStop;
  logic [3:0]  opSymbol;
  logic [15:0] opUnderrunCount;
  logic [1:0]  opState;

  qam_symbol_scheduler #(
    .SYM_PERIOD(8), .PERIOD_W(4), .START_LEVEL(2), .XOFF_LEVEL(6), .XON_LEVEL(3)
  ) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable), .ipClearStats(ipClearStats),
    .ipFifoData(ipFifoData), .ipFifoEmpty(ipFifoEmpty), .ipFifoCount(ipFifoCount),
    .opFifoRdEn(opFifoRdEn), .opSymbol(opSymbol), .opSymbolValid(opSymbolValid),
    .opUnderrun(opUnderrun), .opUnderrunCount(opUnderrunCount),
    .opFlowStop(opFlowStop), .opState(opState)
  );

  always #5 ipClk = ~ipClk;

  // FIFO model; the override lets the bench force count/empty directly.
  logic [15:0] mem [0:63];
  logic [7:0]  wp = 8'd0, rp = 8'd0, fcnt;
  logic        ovr_en = 1'b0, ovr_empty = 1'b1;
  logic [12:0] ovr_cnt = 13'd0;

  assign fcnt        = wp - rp;
  assign ipFifoData  = ovr_en ? 16'h0000 : mem[rp[5:0]];
  assign ipFifoEmpty = ovr_en ? ovr_empty : (fcnt == 8'd0);
  assign ipFifoCount = ovr_en ? ovr_cnt : {5'd0, fcnt};

  always @(posedge ipClk) if (opFifoRdEn) rp <= rp + 8'd1;

  int n_chk = 0, n_err = 0;
  logic [4:0] sb[$];
  int cyc = 0, last = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input bit expect_out);
    mem[wp[5:0]] = w;
    wp = wp + 8'd1;
    if (expect_out)
      for (int k = 0; k < 4; k++) sb.push_back({(k == 0), w[4*k +: 4]});
  endtask

  task automatic wait_sb(input int n, input int budget);
    for (int i = 0; i < budget && sb.size() != n; i++) @(negedge ipClk);
    chk("sb_drain", sb.size(), n);
  endtask

  task automatic underrun_once(input bit clr, input logic [15:0] exp_cnt);
    ovr_cnt = 13'd2; ovr_empty = 1'b0;
    @(negedge ipClk);
    chk("u_run", opState, 2);
    ovr_cnt = 13'd0; ovr_empty = 1'b1;
    repeat (7) @(negedge ipClk);
    ipClearStats = clr;
    @(negedge ipClk);
    ipClearStats = 1'b0;
    chk("u_pulse", opUnderrun, 1);
    chk("u_count", opUnderrunCount, exp_cnt);
    chk("u_state", opState, 1);
  endtask

  // Output monitor: symbol/pop against scoreboard and symbol spacing.
  always @(posedge ipClk) begin
    logic [4:0] e;
    #1;
    cyc++;
    if (opState != 2'd2 && !opSymbolValid) last = -1;
    if (opSymbolValid) begin
      if (sb.size() == 0) chk("unexp_sym", opSymbolValid, 0);
      else begin
        e = sb.pop_front();
        chk("sym", opSymbol, e[3:0]);
        chk("rden", opFifoRdEn, e[4]);
        if (last >= 0) chk("spacing", cyc - last, 8);
      end
      last = cyc;
    end else if (opFifoRdEn) chk("rden_orphan", opFifoRdEn, 0);
  end

  initial begin
    int ramp[16];
    logic exp_flow;
    ramp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 0};

    #2 ipReset = 1'b0;
    #1;
    chk("rst_state", opState, 0);
    chk("rst_outs", {opFifoRdEn, opSymbol, opSymbolValid, opUnderrun, opFlowStop}, 0);
    chk("rst_ucnt", opUnderrunCount, 0);
    repeat (2) @(negedge ipClk);
    ipReset = 1'b1;

    // 1: two words, prime then run
    push_word(16'hA5C3, 1'b1);
    push_word(16'h1234, 1'b1);
    ipEnable = 1'b1;
    @(negedge ipClk); chk("t1_prime", opState, 1);
    @(negedge ipClk); chk("t1_run", opState, 2);
    wait_sb(0, 100);

    // 2: FIFO empty at the next word boundary
    for (int i = 0; i < 20 && !opUnderrun; i++) @(negedge ipClk);
    chk("t2_und", opUnderrun, 1);
    chk("t2_cnt", opUnderrunCount, 1);
    chk("t2_state", opState, 1);

    // 3: refill, drop enable mid-word
    push_word(16'hBEEF, 1'b1);
    push_word(16'h7777, 1'b0);
    wait_sb(3, 40);
    repeat (3) @(negedge ipClk);
    ipEnable = 1'b0;
    wait_sb(0, 40);
    @(negedge ipClk); chk("t3_idle", opState, 0);
    repeat (20) @(negedge ipClk);
    chk("t3_nopop", ipFifoCount, 1);

    // 4: flow-control hysteresis
    ovr_en = 1'b1;
    exp_flow = 1'b0;
    foreach (ramp[i]) begin
      ovr_cnt = 13'(ramp[i]);
      @(negedge ipClk);
      if (ramp[i] >= 6) exp_flow = 1'b1;
      else if (ramp[i] <= 3) exp_flow = 1'b0;
      chk($sformatf("t4_flow_%0d", i), opFlowStop, exp_flow);
    end

    // 5: build count to 5, then clear coincident with an underrun
    ovr_cnt = 13'd0; ovr_empty = 1'b1;
    ipEnable = 1'b1;
    @(negedge ipClk); chk("t5_prime", opState, 1);
    for (int i = 2; i <= 5; i++) underrun_once(1'b0, 16'(i));
    underrun_once(1'b1, 16'd0);

    // 6: reset mid-word in RUN
    ovr_en = 1'b0;
    for (int k = 0; k < 4; k++) sb.push_back({(k == 0), 4'h7});
    push_word(16'h4321, 1'b0);
    wait_sb(3, 40);
    repeat (2) @(negedge ipClk);
    ipReset = 1'b0;
    #1;
    chk("t6_outs", {opFifoRdEn, opSymbol, opSymbolValid, opUnderrun, opFlowStop, opState}, 0);
    chk("t6_ucnt", opUnderrunCount, 0);
    sb.delete();
    repeat (2) @(negedge ipClk);
    chk("t6_rden", opFifoRdEn, 0);
    ipReset = 1'b1;
    @(negedge ipClk); chk("t6_prime", opState, 1);
    repeat (10) @(negedge ipClk);
    chk("t6_hold", opState, 1);
    chk("t6_fifo", ipFifoCount, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
